// File: rtl/bennett_pkg.sv
// Shared types and constants for the Bennett adiabatic clock bus monitor.
package bennett_pkg;

  typedef enum logic [2:0] {
    SYNC = 3'd0,
    UP   = 3'd1,
    TOP  = 3'd2,
    DOWN = 3'd3,
    ERR  = 3'd4
  } bmon_state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_THERM = 3'd1;
  localparam logic [2:0] ERR_COMPL = 3'd2;
  localparam logic [2:0] ERR_REV   = 3'd3;
  localparam logic [2:0] ERR_JUMP  = 3'd4;
  localparam logic [2:0] ERR_STALL = 3'd5;

  // Bits needed to hold a level in 0..width inclusive.
  function automatic int bmon_lvl_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bennett_therm_decode.sv
// Combinational decode of one bus word: level k (popcount of clkp), whether
// clkp is a thermometer code, and whether clkn is its exact complement.
module bennett_therm_decode #(
  parameter int WIDTH = 13,
  parameter int LVL_W = 4
) (
  input  logic [WIDTH-1:0] clkp,
  input  logic [WIDTH-1:0] clkn,
  output logic [LVL_W-1:0] k,
  output logic             is_therm,
  output logic             is_compl
);

  logic [WIDTH-1:0] clkp_inc;

  // A thermometer word (2^k)-1 has no set bit left over after x & (x+1).
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      k = k + LVL_W'(clkp[i]);
    end
    clkp_inc = clkp + WIDTH'(1);
    is_therm = ((clkp & clkp_inc) == '0);
    is_compl = (clkn == ~clkp);
  end

endmodule

// File: rtl/bennett_clock_monitor.sv
// Receiving-end sequence checker for the Bennett multi-phase clock bus.
// Locks on level 0, follows the 0..WIDTH..0 ramp, emits full-charge and
// cycle-complete strobes, and latches the first illegal-pattern cause.
module bennett_clock_monitor
  import bennett_pkg::*;
#(
  parameter int  WIDTH    = 13,
  parameter int  MAX_HOLD = 4,
  parameter int  CNT_W    = 16,
  localparam int LVL_W    = bmon_lvl_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] clkp,
  input  logic [WIDTH-1:0] clkn,
  input  logic             err_clr,
  output logic             locked,
  output logic [LVL_W-1:0] level,
  output logic             ramp_up,
  output logic             full_strobe,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err,
  output logic [2:0]       err_code
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  bmon_state_t      state_q, state_d;
  logic             locked_q, locked_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             ramp_up_q, ramp_up_d;
  logic             full_strobe_q, full_strobe_d;
  logic             cycle_done_q, cycle_done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic             err_q, err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [LVL_W-1:0] dec_k;
  logic             dec_therm;
  logic             dec_compl;

  bennett_therm_decode #(
    .WIDTH (WIDTH),
    .LVL_W (LVL_W)
  ) u_decode (
    .clkp     (clkp),
    .clkn     (clkn),
    .k        (dec_k),
    .is_therm (dec_therm),
    .is_compl (dec_compl)
  );

  // Levels extended by one bit so prev+1 / k+1 never overflow.
  logic [LVL_W:0] k_x;
  logic [LVL_W:0] prev_x;
  logic           word_ok;
  logic           same_lvl;
  logic           step_dn;
  logic           k_zero;
  logic           k_full;
  logic           step_up;
  logic [2:0]     fault;

  // Classify the sampled word against the previous level and pick the
  // highest-priority (lowest-numbered) fault for the tracking states.
  always_comb begin
    k_x      = {1'b0, dec_k};
    prev_x   = {1'b0, level_q};
    word_ok  = dec_therm && dec_compl;
    same_lvl = word_ok && (k_x == prev_x);
    step_up  = word_ok && (k_x == prev_x + (LVL_W+1)'(1));
    step_dn  = word_ok && (k_x + (LVL_W+1)'(1) == prev_x);
    k_zero   = (dec_k == '0);
    k_full   = (k_x == (LVL_W+1)'(WIDTH));

    fault = ERR_NONE;
    if (!dec_therm) begin
      fault = ERR_THERM;
    end else if (!dec_compl) begin
      fault = ERR_COMPL;
    end else begin
      case (state_q)
        UP: begin
          if (k_x < prev_x)                            fault = ERR_REV;
          else if (k_x > prev_x + (LVL_W+1)'(1))       fault = ERR_JUMP;
        end
        TOP: begin
          if (k_x + (LVL_W+1)'(1) < prev_x)            fault = ERR_JUMP;
        end
        DOWN: begin
          if (k_x > prev_x)                            fault = ERR_REV;
          else if (k_x + (LVL_W+1)'(1) < prev_x)       fault = ERR_JUMP;
        end
        default: fault = ERR_NONE;
      endcase
      // Level 0 is the idle level and may be held indefinitely.
      if (fault == ERR_NONE && same_lvl && !k_zero &&
          hold_q == HOLD_W'(MAX_HOLD - 1)) begin
        fault = ERR_STALL;
      end
    end
  end

  // Next-state and registered-output computation for the sequence tracker.
  always_comb begin
    state_d       = state_q;
    locked_d      = locked_q;
    level_d       = level_q;
    ramp_up_d     = ramp_up_q;
    full_strobe_d = 1'b0;
    cycle_done_d  = 1'b0;
    cycle_count_d = cycle_count_q;
    err_d         = err_q;
    err_code_d    = err_code_q;
    hold_d        = hold_q;

    if (word_ok) begin
      level_d = dec_k;
    end

    if (err_clr) begin
      // Clearing wins over any fault detected on the same edge.
      state_d    = SYNC;
      locked_d   = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      hold_d     = '0;
    end else begin
      case (state_q)
        SYNC: begin
          hold_d = '0;
          if (word_ok && k_zero) begin
            state_d   = UP;
            locked_d  = 1'b1;
            ramp_up_d = 1'b1;
          end
        end
        UP, TOP, DOWN: begin
          if (fault != ERR_NONE) begin
            state_d    = ERR;
            locked_d   = 1'b0;
            err_d      = 1'b1;
            err_code_d = fault;
            hold_d     = '0;
          end else begin
            hold_d = (same_lvl && !k_zero) ? hold_q + HOLD_W'(1) : '0;
            if (state_q == UP && step_up && k_full) begin
              state_d       = TOP;
              full_strobe_d = 1'b1;
            end else if ((state_q == TOP || state_q == DOWN) && step_dn && k_zero) begin
              // Covers WIDTH==1, where leaving the top lands straight on 0.
              state_d       = UP;
              ramp_up_d     = 1'b1;
              cycle_done_d  = 1'b1;
              cycle_count_d = cycle_count_q + CNT_W'(1);
            end else if (state_q == TOP && step_dn) begin
              state_d   = DOWN;
              ramp_up_d = 1'b0;
            end
          end
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d  = SYNC;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= SYNC;
      locked_q      <= 1'b0;
      level_q       <= '0;
      ramp_up_q     <= 1'b1;
      full_strobe_q <= 1'b0;
      cycle_done_q  <= 1'b0;
      cycle_count_q <= '0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      locked_q      <= locked_d;
      level_q       <= level_d;
      ramp_up_q     <= ramp_up_d;
      full_strobe_q <= full_strobe_d;
      cycle_done_q  <= cycle_done_d;
      cycle_count_q <= cycle_count_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      hold_q        <= hold_d;
    end
  end

  assign locked      = locked_q;
  assign level       = level_q;
  assign ramp_up     = ramp_up_q;
  assign full_strobe = full_strobe_q;
  assign cycle_done  = cycle_done_q;
  assign cycle_count = cycle_count_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_bennett_clock_monitor.sv
// Directed self-checking bench for bennett_clock_monitor (WIDTH=13).
// A second instance with a 4-bit cycle counter shares the stimulus to
// exercise counter wrap.
module tb_bennett_clock_monitor;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] clkp;
  logic [W-1:0] clkn;
  logic         err_clr;

  logic         locked, ramp_up, full_strobe, cycle_done, err;
  logic [3:0]   level;
  logic [15:0]  cycle_count;
  logic [2:0]   err_code;

  logic         locked4, ramp_up4, full_strobe4, cycle_done4, err4;
  logic [3:0]   level4;
  logic [3:0]   cycle_count4;
  logic [2:0]   err_code4;

  int checks   = 0;
  int failures = 0;
  int fs_cnt   = 0;
  int cd_cnt   = 0;

  always #5 clk = ~clk;

  bennett_clock_monitor #(.WIDTH(W), .MAX_HOLD(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clkp(clkp), .clkn(clkn), .err_clr(err_clr),
    .locked(locked), .level(level), .ramp_up(ramp_up),
    .full_strobe(full_strobe), .cycle_done(cycle_done),
    .cycle_count(cycle_count), .err(err), .err_code(err_code)
  );

  bennett_clock_monitor #(.WIDTH(W), .MAX_HOLD(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clkp(clkp), .clkn(clkn), .err_clr(err_clr),
    .locked(locked4), .level(level4), .ramp_up(ramp_up4),
    .full_strobe(full_strobe4), .cycle_done(cycle_done4),
    .cycle_count(cycle_count4), .err(err4), .err_code(err_code4)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [W-1:0] therm(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (i < k) v[i] = 1'b1;
    end
    return v;
  endfunction

  // One clk per call; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (full_strobe) fs_cnt++;
    if (cycle_done)  cd_cnt++;
  endtask

  task automatic step(input int k);
    clkp = therm(k);
    clkn = ~therm(k);
    tick();
  endtask

  task automatic step_raw(input logic [W-1:0] p, input logic [W-1:0] n);
    clkp = p;
    clkn = n;
    tick();
  endtask

  task automatic run_cycle();
    for (int k = 1; k <= W; k++) step(k);
    for (int k = W - 1; k >= 0; k--) step(k);
  endtask

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_locked"},  int'(locked), 0);
    check_val({pfx, "_level"},   int'(level), 0);
    check_val({pfx, "_ramp_up"}, int'(ramp_up), 1);
    check_val({pfx, "_fstrobe"}, int'(full_strobe), 0);
    check_val({pfx, "_cdone"},   int'(cycle_done), 0);
    check_val({pfx, "_count"},   int'(cycle_count), 0);
    check_val({pfx, "_err"},     int'(err), 0);
    check_val({pfx, "_code"},    int'(err_code), 0);
  endtask

  task automatic clear_and_relock();
    err_clr = 1'b1;
    step(0);
    err_clr = 1'b0;
    step(0);
  endtask

  initial begin
    reset   = 1'b0;
    err_clr = 1'b0;
    clkp    = '0;
    clkn    = '1;

    // Reset values
    step(0);
    step(0);
    check_reset_state("rst");

    // Clean sequence, three full cycles
    reset = 1'b1;
    step(0);
    check_val("lock_first_k0", int'(locked), 1);
    fs_cnt = 0;
    cd_cnt = 0;
    for (int c = 0; c < 3; c++) run_cycle();
    check_val("clean_fstrobes", fs_cnt, 3);
    check_val("clean_cdones", cd_cnt, 3);
    check_val("clean_count", int'(cycle_count), 3);
    check_val("clean_err", int'(err), 0);
    for (int k = 1; k <= W; k++) step(k);
    check_val("top_level", int'(level), 13);
    check_val("top_ramp", int'(ramp_up), 1);
    step(12);
    check_val("down_ramp", int'(ramp_up), 0);

    // Start mid-ramp after reset: no lock, no error until level 0
    reset = 1'b0;
    step(7);
    reset = 1'b1;
    for (int k = 7; k >= 1; k--) step(k);
    check_val("midramp_locked", int'(locked), 0);
    check_val("midramp_err", int'(err), 0);
    step(0);
    check_val("midramp_lock", int'(locked), 1);
    fs_cnt = 0;
    for (int k = 1; k <= 12; k++) step(k);
    check_val("midramp_no_early_fs", fs_cnt, 0);
    step(13);
    check_val("midramp_fs_at_13", int'(full_strobe), 1);
    for (int k = 12; k >= 0; k--) step(k);
    check_val("midramp_count", int'(cycle_count), 1);

    // Non-thermometer word at k=5
    for (int k = 1; k <= 5; k++) step(k);
    step_raw(13'b0000000010111, ~13'b0000000010111);
    check_val("therm_err", int'(err), 1);
    check_val("therm_code", int'(err_code), 1);
    check_val("therm_locked", int'(locked), 0);
    err_clr = 1'b1;
    step(4);
    err_clr = 1'b0;
    check_val("clr_err", int'(err), 0);
    check_val("clr_code", int'(err_code), 0);
    for (int k = 3; k >= 1; k--) step(k);
    check_val("clr_not_locked", int'(locked), 0);
    step(0);
    check_val("clr_relock", int'(locked), 1);
    check_val("clr_count_kept", int'(cycle_count), 1);

    // Jump 4 -> 6 while charging
    for (int k = 1; k <= 4; k++) step(k);
    step(6);
    check_val("jump_code", int'(err_code), 4);
    clear_and_relock();

    // Reversal 9 -> 10 while discharging, then a later fault is ignored
    for (int k = 1; k <= W; k++) step(k);
    for (int k = 12; k >= 9; k--) step(k);
    step(10);
    check_val("rev_code", int'(err_code), 3);
    step_raw(therm(10), ~therm(10) ^ 13'h0001);
    check_val("sticky_code", int'(err_code), 3);
    clear_and_relock();

    // Complement fault
    step(1);
    step_raw(therm(2), ~therm(2) ^ 13'h1000);
    check_val("compl_code", int'(err_code), 2);
    clear_and_relock();

    // err_clr and a jump on the same edge: clear wins
    for (int k = 1; k <= 3; k++) step(k);
    err_clr = 1'b1;
    step(5);
    err_clr = 1'b0;
    check_val("clr_wins_err", int'(err), 0);
    check_val("clr_wins_locked", int'(locked), 0);
    step(0);

    // Stall: level 8 sampled five times in a row
    for (int k = 1; k <= 8; k++) step(k);
    for (int i = 0; i < 3; i++) step(8);
    check_val("stall_4th_no_err", int'(err), 0);
    step(8);
    check_val("stall_5th_err", int'(err), 1);
    check_val("stall_code", int'(err_code), 5);
    clear_and_relock();

    // Idle at level 0 is unlimited
    for (int i = 0; i < 50; i++) step(0);
    check_val("idle_err", int'(err), 0);
    check_val("idle_locked", int'(locked), 1);

    // 16 cycles: 4-bit counter wraps, 16-bit does not
    reset = 1'b0;
    step(0);
    reset = 1'b1;
    step(0);
    for (int c = 0; c < 16; c++) run_cycle();
    check_val("wrap_count4", int'(cycle_count4), 0);
    check_val("wrap_count16", int'(cycle_count), 16);
    check_val("wrap_cdone4", int'(cycle_done4), 1);
    check_val("wrap_fs4", int'(full_strobe4), 0);
    check_val("wrap_locked4", int'(locked4), 1);
    check_val("wrap_ramp4", int'(ramp_up4), 1);
    check_val("wrap_level4", int'(level4), 0);
    check_val("wrap_err4", int'(err4), 0);
    check_val("wrap_code4", int'(err_code4), 0);

    // Reset at k=10 mid-ramp
    for (int k = 1; k <= 10; k++) step(k);
    reset = 1'b0;
    step(10);
    check_reset_state("midrst");
    reset = 1'b1;
    step(10);
    step(11);
    check_val("midrst_no_lock", int'(locked), 0);
    check_val("midrst_no_err", int'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
